sccb_cfg_ctrl: RTL and testbench

- Power-up configuration sequencer for the OV7670 camera's SCCB (I2C-like) port.
- Walks an external register table of {reg_addr, reg_data} words and issues one 3-phase SCCB write per entry: ID byte, register address, data.
- Sits between the top-level start/reset logic and the camera pins; pixel capture is gated on done_o.

---
 rtl/sccb_cfg_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_sccb_cfg_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_cfg_ctrl.sv
// sccb_cfg_ctrl: power-up configuration sequencer for the OV7670 SCCB port.
//
// Walks an external {reg_addr, reg_data} table starting at index 0 and issues one
// 3-phase SCCB write per entry (ID byte, register address, data), each byte
// followed by a released ack slot that is not sampled. A table word of 16'hFFFF
// ends the walk, as does reaching the last table index (no wrap to 0).
//
// Optional feature (macro SCCB_DELAY_CMD_EN): the table word 16'hFFF0 becomes a
// 10 ms delay command with the bus idle, instead of an ordinary write.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset; aborts any transfer without a stop
//   start_i      1-cycle pulse, begin table walk (honoured only when idle/done)
//   rom_addr_o   table index
//   rom_data_i   table word {reg, data}, valid 1 clk after rom_addr_o changes
//   sio_c        SCCB clock, push-pull
//   sio_d_oe     1 = pull SIO_D low, 0 = release (pull-up gives 1)
//   busy_o       walk in progress
//   done_o       table complete; held until the next start_i
//   entry_cnt_o  writes issued in the current/last walk
module sccb_cfg_ctrl #(
    parameter int unsigned QTR_CYCLES      = 250,    // clks per quarter-bit, >= 2
    parameter logic [7:0]  DEV_ID          = 8'h42,
    parameter int unsigned ADDR_W          = 8,
    parameter int unsigned GAP_QTRS        = 8,      // >= 1
    parameter int unsigned DELAY_MS_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [15:0]       rom_data_i,
    output logic              sio_c,
    output logic              sio_d_oe,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] entry_cnt_o
);

    localparam int unsigned QCNT_W = $clog2(QTR_CYCLES);
    // Quarter index must hold 0..3 inside a bit and 0..GAP_QTRS-1 in the gap.
    localparam int unsigned QIDX_W = $clog2(GAP_QTRS + 4);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StStart,
        StBits,
        StStop,
        StGap,
`ifdef SCCB_DELAY_CMD_EN
        StDelay,
`endif
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
    logic [QIDX_W-1:0]   qidx_q, qidx_d;
    logic [4:0]          bit_q, bit_d;       // bits left to send after the current one
    logic [26:0]         shreg_q, shreg_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                tick;
    logic                bus_active;

`ifdef SCCB_DELAY_CMD_EN
    localparam int unsigned DLY_TOTAL = 10 * DELAY_MS_CYCLES;
    localparam int unsigned DLY_W     = $clog2(DLY_TOTAL);
    logic [DLY_W-1:0]    dly_q, dly_d;
`endif

    assign bus_active = (state_q == StStart) || (state_q == StBits) ||
                        (state_q == StStop)  || (state_q == StGap);
    assign tick       = (qcnt_q == QCNT_W'(QTR_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            qcnt_q  <= '0;
            qidx_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef SCCB_DELAY_CMD_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qidx_q  <= qidx_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef SCCB_DELAY_CMD_EN
            dly_q   <= dly_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        qidx_d  = qidx_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef SCCB_DELAY_CMD_EN
        dly_d   = dly_q;
`endif
        // Quarter timer runs only while the bus is sequenced, so every phase
        // starts on a fresh quarter.
        qcnt_d = (bus_active && !tick) ? qcnt_q + QCNT_W'(1) : '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                shreg_d = {DEV_ID, 1'b1, rom_data_i[15:8], 1'b1, rom_data_i[7:0], 1'b1};
                qidx_d  = '0;
                bit_d   = 5'd26;
                if (rom_data_i == 16'hFFFF) begin
                    state_d = StDone;
`ifdef SCCB_DELAY_CMD_EN
                end else if (rom_data_i == 16'hFFF0) begin
                    dly_d   = '0;
                    state_d = StDelay;
`endif
                end else begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick) begin
                    if (qidx_q == QIDX_W'(1)) begin
                        qidx_d  = '0;
                        state_d = StBits;
                    end else begin
                        qidx_d = qidx_q + QIDX_W'(1);
                    end
                end
            end
            StBits: begin
                if (tick) begin
                    if (qidx_q == QIDX_W'(3)) begin
                        qidx_d  = '0;
                        shreg_d = {shreg_q[25:0], 1'b0};
                        if (bit_q == 5'd0) begin
                            state_d = StStop;
                        end else begin
                            bit_d = bit_q - 5'd1;
                        end
                    end else begin
                        qidx_d = qidx_q + QIDX_W'(1);
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (qidx_q == QIDX_W'(2)) begin
                        qidx_d  = '0;
                        cnt_d   = cnt_q + ADDR_W'(1);
                        state_d = StGap;
                    end else begin
                        qidx_d = qidx_q + QIDX_W'(1);
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    if (qidx_q == QIDX_W'(GAP_QTRS - 1)) begin
                        qidx_d = '0;
                        // Last table index ends the walk rather than wrapping to 0.
                        if (addr_q == {ADDR_W{1'b1}}) begin
                            state_d = StDone;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                    end else begin
                        qidx_d = qidx_q + QIDX_W'(1);
                    end
                end
            end
`ifdef SCCB_DELAY_CMD_EN
            StDelay: begin
                if (dly_q == DLY_W'(DLY_TOTAL - 1)) begin
                    if (addr_q == {ADDR_W{1'b1}}) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StFetch;
                    end
                end else begin
                    dly_d = dly_q + DLY_W'(1);
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bus pins decode directly from registered state, so they only move on
    // quarter boundaries (and on the DECODE->START edge for the start condition).
    always_comb begin
        sio_c    = 1'b1;
        sio_d_oe = 1'b0;
        case (state_q)
            StStart: begin
                sio_c    = (qidx_q == '0);
                sio_d_oe = 1'b1;
            end
            StBits: begin
                sio_c    = qidx_q[1];            // low in q0/q1, high in q2/q3
                sio_d_oe = ~shreg_q[26];
            end
            StStop: begin
                sio_c    = (qidx_q != '0);
                sio_d_oe = (qidx_q != QIDX_W'(2));
            end
            default: begin
                sio_c    = 1'b1;
                sio_d_oe = 1'b0;
            end
        endcase
    end

    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = (state_q == StDone);
    assign rom_addr_o  = addr_q;
    assign entry_cnt_o = cnt_q;

endmodule

// File: tb/tb_sccb_cfg_ctrl.sv
module tb_sccb_cfg_ctrl;

    localparam int unsigned Q   = 4;
    localparam int unsigned GAP = 8;
    localparam int unsigned AW  = 2;
    localparam int unsigned DMS = 10;
    localparam logic [7:0]  ID  = 8'h42;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] rom_addr_o;
    logic [AW-1:0] entry_cnt_o;
    logic [15:0]   rom_data_i = 16'h0;
    logic          sio_c, sio_d_oe, busy_o, done_o;
    logic [15:0]   rom [4];

    always #5 clk = ~clk;

    sccb_cfg_ctrl #(
        .QTR_CYCLES      (Q),
        .DEV_ID          (ID),
        .ADDR_W          (AW),
        .GAP_QTRS        (GAP),
        .DELAY_MS_CYCLES (DMS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .rom_addr_o  (rom_addr_o),
        .rom_data_i  (rom_data_i),
        .sio_c       (sio_c),
        .sio_d_oe    (sio_d_oe),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .entry_cnt_o (entry_cnt_o)
    );

    // Synchronous table ROM: one clock of read latency.
    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SCCB decoder, sampled on the falling clk edge.
    int          cyc = 0;
    logic        prev_scl = 1'b1;
    logic        prev_oe = 1'b0;
    bit          in_frame = 0;
    bit          stop_valid = 0;
    int          nbits, rises, t_start, t_stop;
    int          last_gap = 0;
    int          scl_rises = 0;
    logic [26:0] frame;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            in_frame   = 0;
            stop_valid = 0;
        end else begin
            if (!busy_o) stop_valid = 0;
            if (sio_c && !prev_scl) scl_rises++;
            if (sio_c && prev_scl && sio_d_oe && !prev_oe) begin
                in_frame = 1;
                nbits    = 0;
                rises    = 0;
                t_start  = cyc;
                if (stop_valid) begin
                    last_gap = cyc - t_stop;
                    chk("gap_idle", 32'(last_gap >= int'(GAP * Q)), 32'd1);
                end
            end else if (sio_c && prev_scl && !sio_d_oe && prev_oe && in_frame) begin
                in_frame   = 0;
                t_stop     = cyc;
                stop_valid = 1;
                // Start to stop release spans all 113 quarters but the last.
                chk("write_span", 32'(t_stop - t_start), 32'(112 * Q));
                chk("scl_rises_per_write", 32'(rises), 32'd28);
                chk("dev_id", 32'(frame[26:19]), 32'(ID));
                chk("ack_released", 32'({frame[18], frame[9], frame[0]}), 32'b111);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'({frame[17:10], frame[8:1]}), 32'hDEAD);
                end else begin
                    chk("decoded_word", 32'({frame[17:10], frame[8:1]}),
                        32'(exp_q.pop_front()));
                end
            end else if (sio_d_oe != prev_oe) begin
                chk("sda_edge_scl_low", 32'(sio_c), 32'd0);
            end
            if (in_frame && sio_c && !prev_scl) begin
                rises++;
                if (nbits < 27) begin
                    frame = {frame[25:0], ~sio_d_oe};
                    nbits++;
                end
            end
        end
        prev_scl = sio_c;
        prev_oe  = sio_d_oe;
    end

    task automatic load(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
        rom[0] = a;
        rom[1] = b;
        rom[2] = c;
        rom[3] = d;
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 32'(done_o), 32'd1);
        chk("busy_low_at_done", 32'(busy_o), 32'd0);
    endtask

    int          rises0;
    logic [AW-1:0] addr_snap;

    initial begin
        load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        chk("rst_sio_c", 32'(sio_c), 32'd1);
        chk("rst_sio_d_oe", 32'(sio_d_oe), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_entry_cnt", 32'(entry_cnt_o), 32'd0);
        rst = 1'b0;

        // Single write then end marker.
        load(16'h1280, 16'hFFFF, 16'h0000, 16'h0000);
        exp_q.push_back(16'h1280);
        rises0 = scl_rises;
        pulse_start();
        chk("busy_after_start", 32'(busy_o), 32'd1);
        wait_done(3000);
        chk("t1_entry_cnt", 32'(entry_cnt_o), 32'd1);
        chk("t1_scl_rises", 32'(scl_rises - rises0), 32'd28);
        chk("t1_sb_drained", 32'(exp_q.size()), 32'd0);

        // Three writes.
        load(16'h1204, 16'h3A04, 16'h40D0, 16'hFFFF);
        exp_q.push_back(16'h1204);
        exp_q.push_back(16'h3A04);
        exp_q.push_back(16'h40D0);
        rises0 = scl_rises;
        pulse_start();
        wait_done(5000);
        chk("t2_entry_cnt", 32'(entry_cnt_o), 32'd3);
        chk("t2_rom_addr", 32'(rom_addr_o), 32'd3);
        chk("t2_scl_rises", 32'(scl_rises - rises0), 32'd84);
        chk("t2_sb_drained", 32'(exp_q.size()), 32'd0);

        // Empty table: done two clocks after start.
        load(16'hFFFF, 16'h1111, 16'h2222, 16'h3333);
        rises0 = scl_rises;
        pulse_start();
        @(negedge clk);
        chk("t3_done_not_yet", 32'(done_o), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("t3_done_2clk", 32'(done_o), 32'd1);
        chk("t3_entry_cnt", 32'(entry_cnt_o), 32'd0);
        repeat (20) @(negedge clk);
        chk("t3_no_scl", 32'(scl_rises - rises0), 32'd0);

        // Reset in the middle of the bit phase, then replay from index 0.
        load(16'h1204, 16'h3A04, 16'h40D0, 16'hFFFF);
        exp_q.push_back(16'h1204);
        pulse_start();
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_sio_c", 32'(sio_c), 32'd1);
        chk("t4_rst_sio_d_oe", 32'(sio_d_oe), 32'd0);
        chk("t4_rst_busy", 32'(busy_o), 32'd0);
        chk("t4_rst_done", 32'(done_o), 32'd0);
        chk("t4_rst_rom_addr", 32'(rom_addr_o), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'h1204);
        exp_q.push_back(16'h3A04);
        exp_q.push_back(16'h40D0);
        pulse_start();
        wait_done(5000);
        chk("t4_entry_cnt", 32'(entry_cnt_o), 32'd3);
        chk("t4_sb_drained", 32'(exp_q.size()), 32'd0);

        // start_i during a write is ignored.
        exp_q.push_back(16'h1204);
        exp_q.push_back(16'h3A04);
        exp_q.push_back(16'h40D0);
        pulse_start();
        repeat (100) @(negedge clk);
        addr_snap = rom_addr_o;
        pulse_start();
        chk("t5_addr_unchanged", 32'(rom_addr_o), 32'(addr_snap));
        chk("t5_still_busy", 32'(busy_o), 32'd1);
        wait_done(5000);
        chk("t5_entry_cnt", 32'(entry_cnt_o), 32'd3);
        chk("t5_rom_addr", 32'(rom_addr_o), 32'd3);
        chk("t5_sb_drained", 32'(exp_q.size()), 32'd0);

        // No end marker: four writes then stop at the last index (count wraps in 2 bits).
        load(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h3333);
        exp_q.push_back(16'h4444);
        rises0 = scl_rises;
        pulse_start();
        wait_done(6000);
        chk("t6_scl_rises", 32'(scl_rises - rises0), 32'd112);
        chk("t6_entry_cnt", 32'(entry_cnt_o), 32'(AW'(4)));
        chk("t6_rom_addr", 32'(rom_addr_o), 32'd3);
        chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);

        // Delay command word.
        load(16'h1280, 16'hFFF0, 16'h1100, 16'hFFFF);
        exp_q.push_back(16'h1280);
`ifndef SCCB_DELAY_CMD_EN
        exp_q.push_back(16'hFFF0);
`endif
        exp_q.push_back(16'h1100);
        pulse_start();
        wait_done(6000);
`ifdef SCCB_DELAY_CMD_EN
        chk("t7_entry_cnt", 32'(entry_cnt_o), 32'd2);
        chk("t7_delay_idle", 32'(last_gap >= int'(10 * DMS)), 32'd1);
`else
        chk("t7_entry_cnt", 32'(entry_cnt_o), 32'd3);
`endif
        chk("t7_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
